alu_operand_issue: RTL and testbench

//  Operand-fetch/issue stage directly upstream of the 4-bit ALU. Accepts 16-bit instruction words,

---
 rtl/alu_operand_issue_pkg.sv | 41 ++++
 rtl/alu_operand_issue_if.sv | 31 +++
 rtl/alu_operand_issue_regfile.sv | 38 +++
 rtl/alu_operand_issue.sv | 136 +++++++++++++
 tb/tb_alu_operand_issue.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/alu_operand_issue_pkg.sv
// rtl/alu_operand_issue_pkg.sv - opcodes, instruction field slices and skid state type for the operand issue stage
package alu_operand_issue_pkg;

    localparam int DW = 4;
    localparam int AW = 4;

    localparam logic [3:0] OP_NOT = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_LSR = 4'b1000;
    localparam logic [3:0] OP_PAR = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_ADD = 4'b1011;
    localparam logic [3:0] OP_SUB = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_MAC = 4'b1110;
    localparam logic [3:0] OP_MSC = 4'b1111;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int A1_MSB = 11;
    localparam int A1_LSB = 8;
    localparam int A2_MSB = 7;
    localparam int A2_LSB = 4;
    localparam int A3_MSB = 3;
    localparam int A3_LSB = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_NOT, OP_XOR, OP_LSR, OP_PAR, OP_NEG,
            OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_MSC: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_issue_if.sv
// rtl/alu_operand_issue_if.sv - instruction, issue and writeback signals of the operand issue stage
interface alu_operand_issue_if
    import alu_operand_issue_pkg::*;
#(
    parameter int ILL_CW = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic              iss_valid;
    logic              iss_ready;
    logic [3:0]        op;
    logic [DW-1:0]     rs1;
    logic [DW-1:0]     rs2;
    logic [DW-1:0]     rs3;
    logic              wb_en;
    logic              wb_hi_en;
    logic [AW-1:0]     wb_addr;
    logic [2*DW-1:0]   wb_data;
    logic [ILL_CW-1:0] illegal_cnt;

    modport master (
        output instr_valid, instr, iss_ready, wb_en, wb_hi_en, wb_addr, wb_data,
        input  instr_ready, iss_valid, op, rs1, rs2, rs3, illegal_cnt
    );

    modport slave (
        input  instr_valid, instr, iss_ready, wb_en, wb_hi_en, wb_addr, wb_data,
        output instr_ready, iss_valid, op, rs1, rs2, rs3, illegal_cnt
    );
endinterface

// File: rtl/alu_operand_issue_regfile.sv
// rtl/alu_operand_issue_regfile.sv - 16x4 register file, three async read ports, lo/hi nibble write ports
module alu_operand_issue_regfile
    import alu_operand_issue_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_lo,
    input  logic [AW-1:0] wa_lo,
    input  logic [DW-1:0] wd_lo,
    input  logic          we_hi,
    input  logic [AW-1:0] wa_hi,
    input  logic [DW-1:0] wd_hi,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] ra3,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] rd3
);
    logic [DW-1:0] mem [2**AW];

    // wa_lo and wa_hi are always distinct (hi = lo + 1), so the two writes never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we_lo) mem[wa_lo] <= wd_lo;
            if (we_hi) mem[wa_hi] <= wd_hi;
        end
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
    assign rd3 = mem[ra3];

endmodule

// File: rtl/alu_operand_issue.sv
// rtl/alu_operand_issue.sv - operand fetch/issue stage with 2-entry skid; ALU_WB_BYPASS_EN forwards same-cycle writeback
module alu_operand_issue
    import alu_operand_issue_pkg::*;
#(
    parameter int ILL_CW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_issue_if.slave bus
);
    skid_state_t       state_q, state_d;
    logic [15:0]       out_q, out_d;
    logic [15:0]       skid_q, skid_d;
    logic              rdy_q;
    logic [ILL_CW-1:0] cnt_q, cnt_d;

    logic [3:0]    op_in;
    logic [AW-1:0] a1, a2, a3;
    logic [AW-1:0] wb_addr_hi;
    logic          we_hi;
    logic [DW-1:0] rd1, rd2, rd3;
    logic [DW-1:0] src1, src2, src3;
    logic          accept, push, drain;
    logic [15:0]   new_bundle;

    assign op_in      = bus.instr[OP_MSB:OP_LSB];
    assign a1         = bus.instr[A1_MSB:A1_LSB];
    assign a2         = bus.instr[A2_MSB:A2_LSB];
    assign a3         = bus.instr[A3_MSB:A3_LSB];
    assign wb_addr_hi = bus.wb_addr + 1'b1;
    assign we_hi      = bus.wb_en && bus.wb_hi_en;

    alu_operand_issue_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we_lo (bus.wb_en),
        .wa_lo (bus.wb_addr),
        .wd_lo (bus.wb_data[DW-1:0]),
        .we_hi (we_hi),
        .wa_hi (wb_addr_hi),
        .wd_hi (bus.wb_data[2*DW-1:DW]),
        .ra1   (a1),
        .ra2   (a2),
        .ra3   (a3),
        .rd1   (rd1),
        .rd2   (rd2),
        .rd3   (rd3)
    );

`ifdef ALU_WB_BYPASS_EN
    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a, input logic [DW-1:0] rd);
        if (bus.wb_en && bus.wb_addr == a)
            return bus.wb_data[DW-1:0];
        else if (we_hi && wb_addr_hi == a)
            return bus.wb_data[2*DW-1:DW];
        else
            return rd;
    endfunction

    always_comb begin
        src1 = fwd(a1, rd1);
        src2 = fwd(a2, rd2);
        src3 = fwd(a3, rd3);
    end
`else
    assign src1 = rd1;
    assign src2 = rd2;
    assign src3 = rd3;
`endif

    assign new_bundle = {op_in, src1, src2, src3};
    assign accept     = bus.instr_valid && rdy_q;
    assign push       = accept && op_legal(op_in);
    assign drain      = bus.iss_valid && bus.iss_ready;

    // Illegal ops complete the handshake but never occupy a skid slot
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    out_d   = new_bundle;
                end
            end
            ST_ONE: begin
                if (push && drain) begin
                    out_d = new_bundle;
                end else if (push) begin
                    state_d = ST_TWO;
                    skid_d  = new_bundle;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (accept && !op_legal(op_in) && cnt_q != {ILL_CW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != ST_TWO);
            cnt_q   <= cnt_d;
        end
    end

    assign bus.instr_ready = rdy_q;
    assign bus.iss_valid   = (state_q != ST_EMPTY);
    assign bus.op          = out_q[15:12];
    assign bus.rs1         = out_q[11:8];
    assign bus.rs2         = out_q[7:4];
    assign bus.rs3         = out_q[3:0];
    assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// tb/tb_alu_operand_issue.sv - randomized and directed checks of alu_operand_issue against a queue-based model
module tb_alu_operand_issue;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_operand_issue_if #(.ILL_CW(4)) bus ();

    alu_operand_issue #(.ILL_CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef ALU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0]  mregs [16];
    logic [15:0] mq [$];
    int          mcnt;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mread(input logic [3:0] a, input logic we, input logic whe,
                                         input logic [3:0] wa, input logic [7:0] wd);
        logic [3:0] wa1;
        wa1 = wa + 4'd1;
        if (BYP && we && wa == a) return wd[3:0];
        if (BYP && we && whe && wa1 == a) return wd[7:4];
        return mregs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 4'd0;
        mq.delete();
        mcnt = 0;
    endtask

    // Called at a negedge: check outputs, drive one cycle of inputs, advance the model
    task automatic step(input logic iv, input logic [15:0] ins, input logic ir,
                        input logic we, input logic whe, input logic [3:0] wa, input logic [7:0] wd);
        bit         acc;
        logic [3:0] opc;
        logic [3:0] wa1;
        chk_eq("instr_ready", bus.instr_ready, mq.size() < 2);
        chk_eq("iss_valid", bus.iss_valid, mq.size() > 0);
        if (mq.size() > 0) chk_eq("bundle", {bus.op, bus.rs1, bus.rs2, bus.rs3}, mq[0]);
        chk_eq("illegal_cnt", bus.illegal_cnt, mcnt);

        bus.instr_valid = iv;
        bus.instr       = ins;
        bus.iss_ready   = ir;
        bus.wb_en       = we;
        bus.wb_hi_en    = whe;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;

        acc = iv && (mq.size() < 2);
        if (mq.size() > 0 && ir) void'(mq.pop_front());
        if (acc) begin
            opc = ins[15:12];
            if (opc == 4'd0 || opc >= 4'd7)
                mq.push_back({opc, mread(ins[11:8], we, whe, wa, wd),
                              mread(ins[7:4], we, whe, wa, wd), mread(ins[3:0], we, whe, wa, wd)});
            else if (mcnt < 15)
                mcnt++;
        end
        if (we) begin
            mregs[wa] = wd[3:0];
            wa1 = wa + 4'd1;
            if (whe) mregs[wa1] = wd[7:4];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, a, {4'h0, d});
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 4'($urandom), 8'($urandom));
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0;
        bus.iss_ready   = 1'b0;
        bus.wb_en       = 1'b0;
        bus.wb_hi_en    = 1'b0;
        bus.wb_addr     = 4'h0;
        bus.wb_data     = 8'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_eq("reset_iss_valid", bus.iss_valid, 1'b0);
        chk_eq("reset_instr_ready", bus.instr_ready, 1'b1);
        rst_n = 1'b1;

        // Basic issue of a MAC with three distinct sources
        wr(4'd2, 4'b0010);
        wr(4'd4, 4'b0100);
        wr(4'd1, 4'b0001);
        step(1'b1, 16'hE241, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
        chk_eq("mac_valid", bus.iss_valid, 1'b1);
        chk_eq("mac_bundle", {bus.op, bus.rs1, bus.rs2, bus.rs3}, 16'hE241);
        idle(1);

        // Back-pressure: three instructions while the ALU stalls
        step(1'b1, 16'hB124, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
        step(1'b1, 16'hC412, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
        chk_eq("stall_ready_low", bus.instr_ready, 1'b0);
        step(1'b1, 16'h7214, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
        chk_eq("stall_hold", {bus.op, bus.rs1, bus.rs2, bus.rs3}, 16'hB124);
        step(1'b1, 16'h7214, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        chk_eq("stall_second", {bus.op, bus.rs1, bus.rs2, bus.rs3}, 16'hC412);
        step(1'b1, 16'h7214, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        idle(2);

        // Writeback with high nibble wrapping from reg15 to reg0
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 4'd15, 8'hA5);
        step(1'b1, 16'hBF00, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        chk_eq("wrap_rs1", bus.rs1, 4'h5);
        chk_eq("wrap_rs2", bus.rs2, 4'hA);
        idle(1);

        // Same-cycle writeback and read of reg6
        wr(4'd6, 4'b0011);
        step(1'b1, 16'hB600, 1'b1, 1'b1, 1'b0, 4'd6, 8'h07);
        chk_eq("bypass_rs1", bus.rs1, BYP ? 4'b0111 : 4'b0011);
        step(1'b1, 16'hB600, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        chk_eq("reg6_updated", bus.rs1, 4'b0111);
        idle(1);

        // Illegal opcodes are consumed and counted, saturating
        step(1'b1, 16'h3123, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        chk_eq("illegal_no_issue", bus.iss_valid, 1'b0);
        chk_eq("illegal_one", bus.illegal_cnt, 4'd1);
        for (int i = 0; i < 20; i++)
            step(1'b1, {4'($urandom_range(1, 6)), 12'($urandom)}, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        chk_eq("illegal_sat", bus.illegal_cnt, 4'd15);

        rand_steps(300);

        // Reset while traffic is in flight
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_iss_valid", bus.iss_valid, 1'b0);
        chk_eq("midrst_instr_ready", bus.instr_ready, 1'b1);
        chk_eq("midrst_illegal_cnt", bus.illegal_cnt, 4'd0);
        bus.instr_valid = 1'b0;
        bus.wb_en       = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'hB3C9, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        chk_eq("midrst_regs_zero", {bus.rs1, bus.rs2, bus.rs3}, 12'h000);

        rand_steps(300);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
